// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access stage: FSM states and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_pkg;

    // Two-state access FSM; the encoding is visible on the stall output.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int ADDR_W_DEF  = 8;   // default data-RAM address width
    localparam int TIMEOUT_DEF = 15;  // default request timeout in cycles (1..255)
    localparam int CNT_W       = 8;   // width of the timeout counter

endpackage

// File: rtl/mem_timeout_cnt.sv
// Request-timeout counter: 8-bit, synchronous clear and enable, hit when count == TIMEOUT-1.
// Latency: clr/en act on the next clock edge; hit is decoded combinationally from the count.
// Backpressure: none; the owner decides when to clear or advance.
// Ports: clk, rst (async active-low), clr, en, hit.
module mem_timeout_cnt
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: ALU ops pass to a registered write-back bus, ld/st go to data RAM.
// Latency: pass-through 1 cycle; memory ops 1 cycle after dm_ack, or abort after TIMEOUT req cycles.
// Backpressure: stall is high while a RAM transaction is outstanding; inputs are ignored then.
// Ports: in_valid/alu_res/st_data/we/rdest/ld/st from execute; dm_* to data RAM;
//        wb_we/wb_rdest/wb_data to the register file; err is a sticky timeout flag.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       alu_res,
    input  logic [15:0]       st_data,
    input  logic              we,
    input  logic [3:0]        rdest,
    input  logic              ld,
    input  logic              st,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [15:0]       dm_wdata,
    input  logic [15:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              wb_we,
    output logic [3:0]        wb_rdest,
    output logic [15:0]       wb_data,
    output logic              err
);

    state_t     state;
    logic       ld_q;      // in-flight access is a load
    logic [3:0] rdest_q;   // destination of the in-flight load
    logic       accept;
    logic       cnt_en;
    logic       cnt_hit;

    // Address bits above ADDR_W are deliberately dropped.
    logic unused_alu_bits;
    assign unused_alu_bits = ^alu_res;

    assign accept = (state == S_IDLE) && in_valid && (ld || st);
    // The counter only needs to advance while still waiting; the hit cycle exits WAIT.
    assign cnt_en = (state == S_WAIT) && !dm_ack && !cnt_hit;
    assign stall  = (state == S_WAIT);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (cnt_en),
        .hit (cnt_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ld_q     <= 1'b0;
            rdest_q  <= '0;
            dm_req   <= 1'b0;
            dm_wr    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            wb_we    <= 1'b0;
            wb_rdest <= '0;
            wb_data  <= '0;
            err      <= 1'b0;
        end else if (state == S_IDLE) begin
            wb_we <= 1'b0;
            if (in_valid) begin
                if (ld || st) begin
                    ld_q     <= ld;
                    rdest_q  <= rdest;
                    dm_addr  <= alu_res[ADDR_W-1:0];
                    dm_wdata <= st_data;
                    dm_wr    <= !ld;     // ld wins when both are set
                    dm_req   <= 1'b1;
                    state    <= S_WAIT;
                end else begin
                    wb_we    <= we;
                    wb_rdest <= rdest;
                    wb_data  <= alu_res;
                end
            end
        end else begin
            wb_we <= 1'b0;
            // An ack on the timeout cycle still completes the access.
            if (dm_ack) begin
                dm_req <= 1'b0;
                state  <= S_IDLE;
                if (ld_q) begin
                    wb_we    <= 1'b1;
                    wb_data  <= dm_rdata;
                    wb_rdest <= rdest_q;
                end
            end else if (cnt_hit) begin
                dm_req <= 1'b0;
                err    <= 1'b1;
                state  <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus a randomized op stream against a transaction-level model.
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: RAM responder acks after a chosen number of request cycles, or never.
module tb_mem_access;

    localparam int TO = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [15:0]   alu_res = '0;
    logic [15:0]   st_data = '0;
    logic          we = 1'b0;
    logic [3:0]    rdest = '0;
    logic          ld = 1'b0;
    logic          st = 1'b0;
    logic [15:0]   dm_rdata = '0;
    logic          dm_ack = 1'b0;
    logic          stall;
    logic          dm_req;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [15:0]   dm_wdata;
    logic          wb_we;
    logic [3:0]    wb_rdest;
    logic [15:0]   wb_data;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_err  = 1'b0;   // model of the sticky error flag

    always #5 clk = ~clk;

    mem_access #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .alu_res  (alu_res),
        .st_data  (st_data),
        .we       (we),
        .rdest    (rdest),
        .ld       (ld),
        .st       (st),
        .stall    (stall),
        .dm_req   (dm_req),
        .dm_wr    (dm_wr),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .wb_we    (wb_we),
        .wb_rdest (wb_rdest),
        .wb_data  (wb_data),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Random inputs while stalled; the stage must ignore all of them.
    task automatic drive_junk();
        in_valid = 1'($urandom);
        alu_res  = 16'($urandom);
        st_data  = 16'($urandom);
        we       = 1'($urandom);
        rdest    = 4'($urandom);
        ld       = 1'($urandom);
        st       = 1'($urandom);
    endtask

    task automatic do_alu(input logic v_we, input logic [3:0] v_rd, input logic [15:0] v_dat,
                          input logic ack_noise);
        in_valid = 1'b1; we = v_we; ld = 1'b0; st = 1'b0;
        rdest = v_rd; alu_res = v_dat; st_data = 16'($urandom);
        dm_ack = ack_noise;
        tick();
        chk("alu_wb_we", wb_we, v_we);
        chk("alu_wb_rdest", wb_rdest, v_rd);
        chk("alu_wb_data", wb_data, v_dat);
        chk("alu_stall", stall, 1'b0);
        chk("alu_dm_req", dm_req, 1'b0);
        chk("alu_err", err, exp_err);
        dm_ack = 1'b0;
    endtask

    task automatic do_idle();
        drive_junk();
        in_valid = 1'b0;
        dm_ack   = 1'($urandom);
        tick();
        chk("idle_wb_we", wb_we, 1'b0);
        chk("idle_stall", stall, 1'b0);
        chk("idle_dm_req", dm_req, 1'b0);
        chk("idle_err", err, exp_err);
        dm_ack = 1'b0;
    endtask

    // ack_at: request cycle (1-based) in which the RAM acks; 0 or > TO means it never does in time.
    task automatic do_mem(input logic is_ld, input logic both, input logic [15:0] addr,
                          input logic [15:0] sdata, input logic [3:0] rd,
                          input int ack_at, input logic [15:0] rdata);
        logic [AW-1:0] exp_addr;
        bit            done_ok;
        int            n_cyc;
        exp_addr = AW'(addr);
        done_ok  = (ack_at >= 1) && (ack_at <= TO);
        n_cyc    = done_ok ? ack_at : TO;
        in_valid = 1'b1; ld = is_ld; st = is_ld ? both : 1'b1;
        alu_res = addr; st_data = sdata; rdest = rd; we = 1'($urandom);
        dm_ack = 1'b0;
        tick();
        chk("mem_stall", stall, 1'b1);
        chk("mem_dm_req", dm_req, 1'b1);
        chk("mem_dm_addr", dm_addr, exp_addr);
        chk("mem_dm_wr", dm_wr, !is_ld);
        chk("mem_dm_wdata", dm_wdata, sdata);
        chk("mem_wb_we", wb_we, 1'b0);
        for (int c = 1; c <= n_cyc; c++) begin
            if (c > 1) begin
                chk("wait_stall", stall, 1'b1);
                chk("wait_dm_req", dm_req, 1'b1);
                chk("wait_dm_addr", dm_addr, exp_addr);
                chk("wait_dm_wr", dm_wr, !is_ld);
                chk("wait_dm_wdata", dm_wdata, sdata);
                chk("wait_wb_we", wb_we, 1'b0);
            end
            drive_junk();
            dm_ack   = (c == ack_at);
            dm_rdata = (c == ack_at) ? rdata : 16'($urandom);
            tick();
        end
        dm_ack = 1'b0; in_valid = 1'b0; ld = 1'b0; st = 1'b0;
        chk("done_stall", stall, 1'b0);
        chk("done_dm_req", dm_req, 1'b0);
        if (done_ok) begin
            chk("done_wb_we", wb_we, is_ld);
            if (is_ld) begin
                chk("done_wb_rdest", wb_rdest, rd);
                chk("done_wb_data", wb_data, rdata);
            end
        end else begin
            exp_err = 1'b1;
            chk("tmo_wb_we", wb_we, 1'b0);
        end
        chk("done_err", err, exp_err);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_dm_req", dm_req, 1'b0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_dm_addr", dm_addr, 8'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        do_alu(1'b1, 4'd3, 16'h1234, 1'b0);
        do_idle();
        do_mem(1'b1, 1'b0, 16'h0142, 16'h0000, 4'd5, 3, 16'hBEEF);
        do_idle();
        do_mem(1'b0, 1'b0, 16'h0010, 16'hA5A5, 4'd0, 1, 16'h0000);
        do_idle();
        do_mem(1'b1, 1'b0, 16'h0077, 16'h0000, 4'd9, TO, 16'hC0DE);   // ack on timeout cycle
        do_mem(1'b1, 1'b1, 16'hFF20, 16'h1111, 4'd7, 2, 16'h5A5A);    // ld and st both set
        do_alu(1'b0, 4'd2, 16'h0F0F, 1'b1);                           // stray ack in IDLE
        do_mem(1'b1, 1'b0, 16'h0033, 16'h0000, 4'd4, 0, 16'h0000);    // timeout
        do_mem(1'b1, 1'b0, 16'h0034, 16'h0000, 4'd6, 2, 16'h7777);    // err stays set

        // Reset two cycles into WAIT
        in_valid = 1'b1; ld = 1'b1; st = 1'b0; alu_res = 16'h0055; rdest = 4'd8;
        tick();
        drive_junk();
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_dm_req", dm_req, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_wb_we", wb_we, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_idle();
        do_alu(1'b1, 4'd12, 16'hCAFE, 1'b0);

        // Randomized op stream, back-to-back where it happens
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: do_alu(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom));
                1: do_idle();
                default: do_mem(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                                4'($urandom), int'($urandom_range(0, TO + 1)), 16'($urandom));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
